km_pipe: RTL and testbench
==========================

KM_PIPE -- requirements
Module: km_pipe

Interface
REQ-001 SHALL have parameter DW, default 32, operand width; even, 8 to 64.
REQ-002 SHALL have parameter TAGW, default 4, sideband tag width carried with each beat.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rstn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  input beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port in1  input  DW  multiplicand.
REQ-008 SHALL have port in2  input  DW  multiplier.
REQ-009 SHALL have port mode  input  2  00 full product, 01 low half, 10 multiply-accumulate, 11 reserved (treated as 00).
REQ-010 SHALL have port acc_clr  input  1  with beat: zero accumulator before this beat is applied.
REQ-011 SHALL have port in_tag  input  TAGW  sideband, returned unchanged.
REQ-012 SHALL have port out_valid  output  1  result beat present.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port out_L  output  DW  result bits [DW-1:0].
REQ-015 SHALL have port out_H  output  DW  result bits [2DW-1:DW].
REQ-016 SHALL have port out_tag  output  TAGW  tag of the result beat.
REQ-017 SHALL have port inflight  output  2  count of valid beats held in stages 1-3 (0..3).

Function
REQ-018 SHALL split operands: aH=in1[DW-1:DW/2], aL=in1[DW/2-1:0], bH, bL likewise.
REQ-019 SHALL, in stage 1, register z2=aH*bH, z0=aL*bL (DW bits each), sa=aH+aL, sb=bH+bL (DW/2+1 bits each, carry kept), plus mode, acc_clr, tag.
REQ-020 SHALL, in stage 2, register z1=sa*sb-z2-z0 (DW+2 bits, non-negative by construction), z2, z0.
REQ-021 SHALL, in stage 3, form P={z2,z0}+(z1<<DW/2) modulo 2^(2DW) and register the result into the out_L/out_H output register.
REQ-022 SHALL produce {out_H,out_L}=in1*in2 exactly for all unsigned operands in mode 00/11.
REQ-023 SHALL produce out_L=P[DW-1:0], out_H=0 in mode 01.
REQ-024 SHALL, in mode 10, output acc'+P and set acc to acc'+P, where acc' is 0 if acc_clr else acc; 2DW-bit accumulator, wraps modulo 2^(2DW).
REQ-025 SHALL, for acc_clr with mode 00/01, zero the accumulator and output per mode.
REQ-026 SHALL update the accumulator only when a beat enters stage 3; beats in order.
REQ-027 SHALL define advance = !(out_valid && !out_ready); all stages shift only when advance=1.
REQ-028 SHALL drive in_ready=advance; an input beat is accepted iff in_valid && in_ready.
REQ-029 SHALL give latency exactly 3 cycles from acceptance to out_valid with no back-pressure; throughput 1 beat/cycle.
REQ-030 SHALL hold out_L, out_H, out_tag, out_valid stable while out_valid && !out_ready.
REQ-031 SHALL propagate empty stages as bubbles; empty stages never alter the accumulator.
REQ-032 SHALL ignore in1, in2, mode, acc_clr, in_tag when the beat is not accepted.
REQ-033 SHALL update inflight every cycle as the number of set stage-valid bits.

Reset
REQ-034 SHALL, on rstn low, clear all stage valids, out_valid, inflight, accumulator, out_L, out_H, out_tag to 0 immediately.
REQ-035 SHALL discard in-flight beats on reset mid-operation; in_ready=1 on the first edge after rstn rises.

Verification
REQ-036 SHALL cover: DW=32, mode 00, in1=in2=0xFFFFFFFF -> 3 cycles later out_H=0xFFFFFFFE, out_L=0x00000001.
REQ-037 SHALL cover: mode 10, beat 3*5 with acc_clr=1 then 2*7 with acc_clr=0 back-to-back -> outputs 15 then 29, in order.
REQ-038 SHALL cover: mode 01, in1=in2=0x00010000 -> out_L=0, out_H=0; in1=0x12345678, in2=0x10 -> out_L=0x23456780, out_H=0.
REQ-039 SHALL cover: out_ready=0 with 5 consecutive beats offered -> 3 accepted, in_ready=0, inflight=3, then out_ready=1 drains all with none lost or duplicated.
REQ-040 SHALL cover: rstn pulsed low with inflight=3 and accumulator nonzero -> all outputs 0 immediately; next MAC beat 4*4 without acc_clr -> 16.
REQ-041 SHALL cover: 10k random operands, modes, tags and out_ready -> every result matches a 2DW-bit reference model and tags stay in order.

Source files
------------

// File: rtl/km_pipe.sv
// rtl/km_pipe.sv - three-stage Karatsuba multiplier with accumulate mode and valid/ready flow control
// Stage 1 forms partial products, stage 2 the middle term, stage 3 is the output register.
module km_pipe #(
    parameter int DW   = 32,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in1,
    input  logic [DW-1:0]   in2,
    input  logic [1:0]      mode,
    input  logic            acc_clr,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_L,
    output logic [DW-1:0]   out_H,
    output logic [TAGW-1:0] out_tag,
    output logic [1:0]      inflight
);
    localparam int HW = DW / 2;
    localparam int PW = 2 * DW;

    localparam logic [1:0] MODE_LOW = 2'b01;
    localparam logic [1:0] MODE_MAC = 2'b10;

    logic            w_advance;
    logic            w_accept;

    logic            r_s1_v;
    logic [DW-1:0]   r_s1_z2;
    logic [DW-1:0]   r_s1_z0;
    logic [HW:0]     r_s1_sa;
    logic [HW:0]     r_s1_sb;
    logic [1:0]      r_s1_mode;
    logic            r_s1_clr;
    logic [TAGW-1:0] r_s1_tag;

    logic            r_s2_v;
    logic [DW+1:0]   r_s2_z1;
    logic [DW-1:0]   r_s2_z2;
    logic [DW-1:0]   r_s2_z0;
    logic [1:0]      r_s2_mode;
    logic            r_s2_clr;
    logic [TAGW-1:0] r_s2_tag;

    logic            r_out_valid;
    logic [DW-1:0]   r_out_l;
    logic [DW-1:0]   r_out_h;
    logic [TAGW-1:0] r_out_tag;
    logic [PW-1:0]   r_acc;

    logic [HW-1:0]   w_ah;
    logic [HW-1:0]   w_al;
    logic [HW-1:0]   w_bh;
    logic [HW-1:0]   w_bl;
    logic [DW+1:0]   w_sab;
    logic [DW+1:0]   w_z1;
    logic [PW-1:0]   w_p;
    logic [PW-1:0]   w_mac;
    logic [PW-1:0]   w_res;
    logic [PW-1:0]   w_acc_nxt;

    // The whole pipe stalls together whenever a held result is not taken.
    assign w_advance = !(r_out_valid && !out_ready);
    assign w_accept  = in_valid && w_advance;
    assign in_ready  = w_advance;

    assign w_ah = in1[DW-1:HW];
    assign w_al = in1[HW-1:0];
    assign w_bh = in2[DW-1:HW];
    assign w_bl = in2[HW-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_v    <= 1'b0;
            r_s1_z2   <= '0;
            r_s1_z0   <= '0;
            r_s1_sa   <= '0;
            r_s1_sb   <= '0;
            r_s1_mode <= '0;
            r_s1_clr  <= 1'b0;
            r_s1_tag  <= '0;
        end else if (w_advance) begin
            r_s1_v <= in_valid;
            if (w_accept) begin
                r_s1_z2   <= {{HW{1'b0}}, w_ah} * {{HW{1'b0}}, w_bh};
                r_s1_z0   <= {{HW{1'b0}}, w_al} * {{HW{1'b0}}, w_bl};
                r_s1_sa   <= {1'b0, w_ah} + {1'b0, w_al};
                r_s1_sb   <= {1'b0, w_bh} + {1'b0, w_bl};
                r_s1_mode <= mode;
                r_s1_clr  <= acc_clr;
                r_s1_tag  <= in_tag;
            end
        end
    end

    // Middle Karatsuba term; never negative, so the subtraction cannot wrap.
    assign w_sab = {{(HW+1){1'b0}}, r_s1_sa} * {{(HW+1){1'b0}}, r_s1_sb};
    assign w_z1  = w_sab - {2'b00, r_s1_z2} - {2'b00, r_s1_z0};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s2_v    <= 1'b0;
            r_s2_z1   <= '0;
            r_s2_z2   <= '0;
            r_s2_z0   <= '0;
            r_s2_mode <= '0;
            r_s2_clr  <= 1'b0;
            r_s2_tag  <= '0;
        end else if (w_advance) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_z1   <= w_z1;
                r_s2_z2   <= r_s1_z2;
                r_s2_z0   <= r_s1_z0;
                r_s2_mode <= r_s1_mode;
                r_s2_clr  <= r_s1_clr;
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

    assign w_p   = {r_s2_z2, r_s2_z0} + ({{(DW-2){1'b0}}, r_s2_z1} << HW);
    assign w_mac = (r_s2_clr ? '0 : r_acc) + w_p;

    always_comb begin
        w_res     = w_p;
        w_acc_nxt = r_acc;
        case (r_s2_mode)
            MODE_LOW: begin
                w_res = {{DW{1'b0}}, w_p[DW-1:0]};
                if (r_s2_clr) w_acc_nxt = '0;
            end
            MODE_MAC: begin
                w_res     = w_mac;
                w_acc_nxt = w_mac;
            end
            default: begin
                if (r_s2_clr) w_acc_nxt = '0;
            end
        endcase
    end

    // Accumulator moves only with a real beat entering the output register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_l     <= '0;
            r_out_h     <= '0;
            r_out_tag   <= '0;
            r_acc       <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_s2_v;
            if (r_s2_v) begin
                r_out_l   <= w_res[DW-1:0];
                r_out_h   <= w_res[PW-1:DW];
                r_out_tag <= r_s2_tag;
                r_acc     <= w_acc_nxt;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_L     = r_out_l;
    assign out_H     = r_out_h;
    assign out_tag   = r_out_tag;
    assign inflight  = {1'b0, r_s1_v} + {1'b0, r_s2_v} + {1'b0, r_out_valid};

endmodule

// File: tb/tb_km_pipe.sv
// tb/tb_km_pipe.sv - self-checking bench for km_pipe against a per-beat arithmetic reference model
module tb_km_pipe;
    localparam int DW   = 32;
    localparam int TAGW = 4;
    localparam int EW   = TAGW + 2 * DW;

    logic            clk = 1'b0;
    logic            rstn;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in1;
    logic [DW-1:0]   in2;
    logic [1:0]      mode;
    logic            acc_clr;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_L;
    logic [DW-1:0]   out_H;
    logic [TAGW-1:0] out_tag;
    logic [1:0]      inflight;

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0]   exp_q[$];
    logic [EW-1:0]   got_q[$];
    logic [2*DW-1:0] m_acc;

    km_pipe #(.DW(DW), .TAGW(TAGW)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .mode(mode), .acc_clr(acc_clr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_L(out_L), .out_H(out_H),
        .out_tag(out_tag), .inflight(inflight)
    );

    always #5 clk = ~clk;

    // Reference model: each accepted beat is resolved to its final result at acceptance, in order.
    always @(negedge clk) begin
        logic [2*DW-1:0] full;
        logic [2*DW-1:0] res;
        if (!rstn) begin
            m_acc = '0;
        end else begin
            if (in_valid && in_ready) begin
                full = {{DW{1'b0}}, in1} * {{DW{1'b0}}, in2};
                if (mode == 2'b10) begin
                    m_acc = (acc_clr ? '0 : m_acc) + full;
                    res   = m_acc;
                end else begin
                    if (acc_clr) m_acc = '0;
                    res = (mode == 2'b01) ? {{DW{1'b0}}, full[DW-1:0]} : full;
                end
                exp_q.push_back({in_tag, res});
            end
            if (out_valid && out_ready) got_q.push_back({out_tag, out_H, out_L});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] m,
                            input logic c, input logic [TAGW-1:0] t);
        in_valid = 1'b1;
        in1      = a;
        in2      = b;
        mode     = m;
        acc_clr  = c;
        in_tag   = t;
    endtask

    task automatic wait_drain(input int want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (got_q.size() >= want && inflight == 2'd0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in1 = '0; in2 = '0; mode = '0; acc_clr = 1'b0; in_tag = '0;
        repeat (2) tick();
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0h want 0", out_valid); end
        n_tests++; if (inflight !== 2'd0) begin n_fail++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
        n_tests++; if ({out_tag, out_H, out_L} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %0h %0h %0h want 0", out_tag, out_H, out_L); end
        tick();
        rstn = 1'b1;
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0h want 1", in_ready); end
    endtask

    task automatic test_full_max();
        int lat;
        bit ok;
        tick();
        got_q.delete(); exp_q.delete();
        set_beat('1, '1, 2'b00, 1'b0, 4'hA);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL full_max_latency: got %0d want 3", lat); end
        n_tests++; if (out_H !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL full_max_hi: got %0h want fffffffe", out_H); end
        n_tests++; if (out_L !== 32'h0000_0001) begin n_fail++; $display("FAIL full_max_lo: got %0h want 1", out_L); end
        n_tests++; if (out_tag !== 4'hA) begin n_fail++; $display("FAIL full_max_tag: got %0h want a", out_tag); end
        wait_drain(1, ok);
        n_tests++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL full_max_count: got %0d want 1", got_q.size()); end
    endtask

    task automatic test_mac_back_to_back();
        bit ok;
        got_q.delete(); exp_q.delete();
        out_ready = 1'b1;
        set_beat(32'd3, 32'd5, 2'b10, 1'b1, 4'd1);
        tick();
        set_beat(32'd2, 32'd7, 2'b10, 1'b0, 4'd2);
        tick();
        in_valid = 1'b0;
        wait_drain(2, ok);
        n_tests++; if (!ok || got_q.size() != 2) begin n_fail++; $display("FAIL mac_count: got %0d want 2", got_q.size()); end
        else begin
            n_tests++; if (got_q[0] !== {4'd1, 64'd15}) begin n_fail++; $display("FAIL mac_first: got %0h want %0h", got_q[0], {4'd1, 64'd15}); end
            n_tests++; if (got_q[1] !== {4'd2, 64'd29}) begin n_fail++; $display("FAIL mac_second: got %0h want %0h", got_q[1], {4'd2, 64'd29}); end
        end
    endtask

    task automatic test_low_half();
        bit ok;
        got_q.delete(); exp_q.delete();
        set_beat(32'h0001_0000, 32'h0001_0000, 2'b01, 1'b0, 4'd3);
        tick();
        set_beat(32'h1234_5678, 32'h0000_0010, 2'b01, 1'b0, 4'd4);
        tick();
        in_valid = 1'b0;
        wait_drain(2, ok);
        n_tests++; if (!ok || got_q.size() != 2) begin n_fail++; $display("FAIL low_count: got %0d want 2", got_q.size()); end
        else begin
            n_tests++; if (got_q[0] !== {4'd3, 64'd0}) begin n_fail++; $display("FAIL low_wrap: got %0h want %0h", got_q[0], {4'd3, 64'd0}); end
            n_tests++; if (got_q[1] !== {4'd4, 64'h0000_0000_2345_6780}) begin n_fail++; $display("FAIL low_shift: got %0h want %0h", got_q[1], {4'd4, 64'h2345_6780}); end
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] a[5];
        logic [DW-1:0] b[5];
        logic [EW:0]   held;
        int idx;
        int guard;
        bit ok;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) begin a[i] = $urandom; b[i] = $urandom; end
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            set_beat(a[idx], b[idx], 2'b00, 1'b0, 4'(5 + idx));
            @(negedge clk);
            if (in_ready) idx++;
            tick();
        end
        set_beat(a[idx], b[idx], 2'b00, 1'b0, 4'(5 + idx));
        @(negedge clk);
        n_tests++; if (idx !== 3) begin n_fail++; $display("FAIL stall_accepted: got %0d want 3", idx); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %0h want 0", in_ready); end
        n_tests++; if (inflight !== 2'd3) begin n_fail++; $display("FAIL stall_inflight: got %0d want 3", inflight); end
        held = {out_valid, out_tag, out_H, out_L};
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            n_tests++; if ({out_valid, out_tag, out_H, out_L} !== held) begin n_fail++; $display("FAIL stall_hold: got %0h want %0h", {out_valid, out_tag, out_H, out_L}, held); end
        end
        tick();
        out_ready = 1'b1;
        guard = 0;
        while (idx < 5 && guard < 50) begin
            set_beat(a[idx], b[idx], 2'b00, 1'b0, 4'(5 + idx));
            @(negedge clk);
            if (in_ready) idx++;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        wait_drain(5, ok);
        n_tests++; if (!ok || got_q.size() != 5 || exp_q.size() != 5) begin n_fail++; $display("FAIL stall_count: got %0d want 5", got_q.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_beat%0d: got %0h want %0h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        got_q.delete(); exp_q.delete();
        out_ready = 1'b1;
        set_beat(32'd100, 32'd3, 2'b10, 1'b1, 4'd1);
        tick();
        in_valid = 1'b0;
        wait_drain(1, ok);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_beat(32'(c + 1), 32'd9, 2'b10, 1'b0, 4'(2 + c));
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (inflight !== 2'd3) begin n_fail++; $display("FAIL rmid_fill: got %0d want 3", inflight); end
        tick();
        rstn = 1'b0;
        #1;
        n_tests++; if ({out_valid, inflight, out_tag, out_H, out_L} !== '0) begin n_fail++; $display("FAIL rmid_clear: got %0h %0d %0h %0h %0h want 0", out_valid, inflight, out_tag, out_H, out_L); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %0h want 1", in_ready); end
        tick();
        rstn = 1'b1;
        got_q.delete(); exp_q.delete();
        out_ready = 1'b1;
        set_beat(32'd4, 32'd4, 2'b10, 1'b0, 4'd7);
        tick();
        in_valid = 1'b0;
        wait_drain(1, ok);
        n_tests++; if (!ok || got_q.size() != 1) begin n_fail++; $display("FAIL rmid_count: got %0d want 1", got_q.size()); end
        else begin
            n_tests++; if (got_q[0] !== {4'd7, 64'd16}) begin n_fail++; $display("FAIL rmid_acc: got %0h want %0h", got_q[0], {4'd7, 64'd16}); end
        end
    endtask

    function automatic logic [DW-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return DW'(1);
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic test_random();
        int sent;
        int seq;
        int errs;
        bit took;
        bit ok;
        got_q.delete(); exp_q.delete();
        in_valid = 1'b0;
        sent = 0; seq = 0; errs = 0;
        for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
            if (!in_valid && $urandom_range(0, 4) != 0) begin
                set_beat(pick_operand(), pick_operand(), 2'($urandom_range(0, 3)),
                         ($urandom_range(0, 7) == 0), 4'(seq));
                seq++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) sent++;
            tick();
            if (took) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain(sent, ok);
        n_tests++; if (!ok || sent != 10000 || got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d results for %0d beats (sent %0d)", got_q.size(), exp_q.size(), sent); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_beat%0d: got %0h want %0h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_max();
        test_mac_back_to_back();
        test_low_half();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
